// File: rtl/sum_pkg.sv
// Shared types and helpers for the sum_acc streaming accumulator.
package sum_pkg;

   typedef enum logic {
      IDLE,
      ACC
   } state_t;

   // Counter must hold values up to 2**n.
   function automatic int cnt_width(input int n);
      return $clog2((1 << n) + 1);
   endfunction

   function automatic int clamp_len(input int len, input int n);
      return (len > n) ? n : len;
   endfunction

endpackage

// File: rtl/sum_acc_if.sv
// Sample/result bundle for sum_acc; master drives samples, slave returns results.
interface sum_acc_if #(
   parameter int W = 8,
   parameter int N = 4
);
   localparam int LW = $clog2(N + 1);

   logic          clr;
   logic [LW-1:0] len;
   logic          avg;
   logic          in_val;
   logic [W-1:0]  in;
   logic          busy;
   logic          out_val;
   logic [W+N-1:0] res;

   modport master (
      output clr, len, avg, in_val, in,
      input  busy, out_val, res
   );

   modport slave (
      input  clr, len, avg, in_val, in,
      output busy, out_val, res
   );
endinterface

// File: rtl/sum_shr.sv
// Average stage: shift a block sum down by len_q and extend from W bits.
// SUM_ACC_ROUND_EN defined: rounds half toward +infinity; otherwise truncates.
module sum_shr #(
   parameter int W      = 8,
   parameter int N      = 4,
   parameter int SIGNED = 0
) (
   input  logic [W+N-1:0]             acc,
   input  logic [$clog2(N+1)-1:0]     len_q,
   output logic [W+N-1:0]             avg
);
   localparam int  AW  = W + N;
   localparam logic SGN = (SIGNED != 0);

   logic [AW:0]  wide;
   logic [AW:0]  rnd;
   logic [W-1:0] avg_w;

   always_comb begin
      // NOTE: every variable gets a value on every path first so no latch is inferred.
      wide = {SGN & acc[AW-1], acc};
`ifdef SUM_ACC_ROUND_EN
      rnd  = (len_q == '0) ? '0 : ((AW+1)'(1) << (len_q - 1'b1));
`else
      rnd  = '0;
`endif
      wide = wide + rnd;
      if (SGN) avg_w = W'($signed(wide) >>> len_q);
      else     avg_w = W'(wide >> len_q);
      avg  = {{N{SGN & avg_w[W-1]}}, avg_w};
   end
endmodule

// File: rtl/sum_acc.sv
// Streaming decimating accumulator: sums blocks of 2**len samples, emits sum or average.
// Optional SUM_ACC_ROUND_EN (handled in sum_shr) rounds the average.
module sum_acc
   import sum_pkg::*;
#(
   parameter int W      = 8,
   parameter int N      = 4,
   parameter int SIGNED = 0
) (
   input  logic     clk,
   input  logic     rst,
   sum_acc_if.slave bus
);
   localparam int   LW  = $clog2(N + 1);
   localparam int   AW  = W + N;
   localparam int   CW  = cnt_width(N);
   localparam logic SGN = (SIGNED != 0);

   state_t         state_q, state_d;
   logic [AW-1:0]  acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [LW-1:0]  len_q, len_d;
   logic           avg_q, avg_d;
   logic [AW-1:0]  res_q;
   logic           out_val_q;

   logic [LW-1:0]  len_cl;
   logic [AW-1:0]  in_ext;
   logic [CW-1:0]  last_cnt;
   logic [AW-1:0]  fin_acc;
   logic [LW-1:0]  fin_len;
   logic           fin_avg;
   logic [AW-1:0]  avg_val;
   logic           done;

   assign len_cl   = LW'(clamp_len(int'(bus.len), N));
   assign in_ext   = {{N{SGN & bus.in[W-1]}}, bus.in};
   assign last_cnt = CW'((1 << len_q) - 1);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      avg_d   = avg_q;
      done    = 1'b0;
      fin_acc = acc_q + in_ext;
      fin_len = len_q;
      fin_avg = avg_q;
      case (state_q)
         IDLE: begin
            // A block of length 1 completes on its first sample, so use live len/avg.
            fin_acc = in_ext;
            fin_len = len_cl;
            fin_avg = bus.avg;
            if (bus.in_val) begin
               len_d = len_cl;
               avg_d = bus.avg;
               if (len_cl == '0) begin
                  done = 1'b1;
               end else begin
                  acc_d   = in_ext;
                  cnt_d   = CW'(1);
                  state_d = ACC;
               end
            end
         end
         ACC: begin
            if (bus.in_val) begin
               if (cnt_q == last_cnt) begin
                  done    = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  acc_d = fin_acc;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Clear discards the partial block and any completion on the same cycle.
      if (bus.clr) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         done    = 1'b0;
      end
   end

   sum_shr #(.W(W), .N(N), .SIGNED(SIGNED)) u_shr (
      .acc   (fin_acc),
      .len_q (fin_len),
      .avg   (avg_val)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         avg_q     <= 1'b0;
         res_q     <= '0;
         out_val_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         avg_q     <= avg_d;
         out_val_q <= done;
         if (done) res_q <= fin_avg ? avg_val : fin_acc;
      end
   end

   assign bus.busy    = (state_q == ACC);
   assign bus.out_val = out_val_q;
   assign bus.res     = res_q;
endmodule

// File: doc/sum_acc.md
# sum_acc

Streaming decimating accumulator, the sequential successor to the combinational-input adder tree. It accepts one W-bit sample per valid cycle and sums blocks of 2**len consecutive samples, where len is selectable at run time up to N. At the end of each block it emits either the full-precision sum or the average (shift by len), with a one-cycle valid pulse. It sits after ADC/sample front-ends as a decimator or averager.

## Interface
- W, 8: sample width.
- N, 4: maximum log2 block length; 2**N samples max.
- SIGNED, 0: 1 = two's-complement samples, arithmetic shift and sign extension; 0 = unsigned.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous discard of the partial block; returns to IDLE.
- len  in  $clog2(N+1)  log2 block length, 0..N; values >N are clamped to N.
- avg  in  1  0 = output sum, 1 = output average.
- in_val  in  1  sample valid; one sample accepted per cycle when high.
- in  in  W  sample.
- busy  out  1  partial block in progress (state ACC).
- out_val  out  1  one-cycle pulse, result valid.
- res  out  W+N  sum, or average sign/zero-extended from W bits.

## Operation
- States: IDLE (no samples held), ACC (0 < cnt < 2**len_q).
- IDLE, in_val: latch len into len_q and avg into avg_q, acc <= in, cnt <= 1. If len is 0, the block completes immediately and the FSM stays in IDLE. Otherwise it goes to ACC.
- ACC, in_val: acc <= acc + in and cnt increments. The cycle with cnt == 2**len_q - 1 completes the block: result registered, acc cleared, FSM to IDLE.
- len and avg changes while in ACC are ignored until the next block starts.
- Back-to-back blocks: a sample on the cycle after completion starts a new block with no bubble.
- in_val low: state, acc and cnt hold.
- Width: acc is W+N bits; no overflow is possible (worst case 2**N·(2**W−1) fits).
- Sum mode: res = final acc. Upper bits are zero beyond W+len_q for unsigned input; for signed input they are the sign extension.
- Avg mode: res = final acc >> len_q, arithmetic when SIGNED, then extended to W+N. The value always fits in W bits.
- clr: acc and cnt zeroed, FSM to IDLE, no out_val. clr overrides in_val on the same cycle; that sample is discarded.
- clr on a completing cycle: clr wins, no out_val.

## Timing
- Reset values: busy=0, out_val=0, res=0, acc=0, cnt=0, state IDLE.
- Latency: out_val and res are valid exactly 1 cycle after the clk edge that accepts the last sample of a block.
- res holds its value until the next completion. out_val is high for 1 cycle only.
- With in_val held high, out_val pulses every 2**len cycles. With len=0, out_val follows in_val delayed by one cycle.
- rst mid-block: the partial block is lost. The first in_val after rst deasserts starts a fresh block.
- Throughput: 1 sample/cycle, no backpressure. The upstream never stalls.

## Configuration
- SUM_ACC_ROUND_EN defined: the average rounds half toward +infinity, computed as res = (acc + 2**(len_q−1)) >>> len_q with a (W+N+1)-bit intermediate. No rounding is applied when len_q=0.
- Not defined: the average truncates toward −infinity (plain shift). Sum mode is unaffected either way.

## Structure
- Package sum_pkg: state enum (IDLE, ACC), function clamp_len, and a localparam helper for the count width $clog2(2**N+1).
- Sub-module sum_shr: the combinational shift / optional-round stage. Parameters are W, N and SIGNED; inputs are acc and len_q; output is the W+N extended average. The SUM_ACC_ROUND_EN branch lives inside it.

## Test plan
- W=8, N=4, unsigned, len=2, avg=0, samples 10,20,30,40 -> one cycle after the 4th sample: out_val=1, res=100. busy was high for samples 1–3.
- Same samples with avg=1 -> res=25. Then 1,2,2,1 with avg=1 -> res=2 with SUM_ACC_ROUND_EN, res=1 without.
- SIGNED=1, len=1, avg=1, samples −3,−2 -> res=−2 (0xFFE) with rounding, −3 (0xFFD) without. Sum mode gives −5 (0xFFB).
- len=4, sum mode, 16 consecutive samples of 255 -> res=4080 (0xFF0). Continue with 16 more samples of 0 and no gap -> a second pulse exactly 16 cycles later with res=0.
- len=2, then two samples, then clr with in_val=1 -> no out_val, busy=0. The next 4 samples 1,1,1,1 -> res=4.
- len=3 latched, then len changed to 1 mid-block -> the block still completes after 8 samples. Assert rst after 3 samples of the next block -> all outputs 0, and the following full block is correct.
